// File: rtl/dcache_pkg.sv
// Shared types and helpers for the data-cache controller.
package dcache_pkg;

    localparam int unsigned DC_IDX_W  = 5;
    localparam int unsigned DC_TAG_W  = 8;
    localparam int unsigned DC_OFS_W  = 3;
    localparam int unsigned DC_SIZE   = 1 << DC_IDX_W;
    localparam int unsigned DC_ADDR_W = DC_TAG_W + DC_IDX_W + DC_OFS_W;
    localparam int unsigned DC_DATA_W = 64;
    localparam int unsigned MEM_TAG_W = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_LOOKUP,
        S_LD_ISSUE,
        S_LD_WAIT,
        S_ST_ISSUE
    } dc_state_e;

    typedef struct packed {
        logic [DC_TAG_W-1:0] tag;
        logic [DC_IDX_W-1:0] idx;
    } dc_line_addr_t;

    // Byte offset is dropped: every access covers a full 8-byte line.
    function automatic dc_line_addr_t dc_split_addr(input logic [DC_ADDR_W-1:0] addr);
        dc_line_addr_t w_line;
        w_line.tag = addr[DC_ADDR_W-1 -: DC_TAG_W];
        w_line.idx = addr[DC_OFS_W +: DC_IDX_W];
        return w_line;
    endfunction

endpackage

// File: rtl/dcache_arb.sv
// Two-requester round-robin arbiter (load vs. store) with a last-grant register.
module dcache_arb (
    input  logic clock,
    input  logic reset_n,
    input  logic i_en,
    input  logic i_ld_req,
    input  logic i_st_req,
    output logic o_ld_gnt,
    output logic o_st_gnt
);

    logic r_last_st;
    logic w_ld_wins;

    // On a tie the side that did not win last time goes first.
    assign w_ld_wins = i_ld_req & (~i_st_req | r_last_st);
    assign o_ld_gnt  = i_en & w_ld_wins;
    assign o_st_gnt  = i_en & i_st_req & ~w_ld_wins;

    // Remember which side was granted most recently; reset favours the load.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_st <= 1'b1;
        end else if (o_ld_gnt) begin
            r_last_st <= 1'b0;
        end else if (o_st_gnt) begin
            r_last_st <= 1'b1;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Blocking controller for the direct-mapped data cache: load hit/miss-fill and
// write-through, write-allocate stores, one transaction at a time.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    // load requester
    input  logic                 ld_req,
    input  logic [DC_ADDR_W-1:0] ld_addr,
    output logic                 ld_ready,
    output logic                 ld_resp_valid,
    output logic [DC_DATA_W-1:0] ld_resp_data,
    // store requester
    input  logic                 st_req,
    input  logic [DC_ADDR_W-1:0] st_addr,
    input  logic [DC_DATA_W-1:0] st_data,
    output logic                 st_ready,
    output logic                 st_done,
    // cache lookup port
    output logic [DC_IDX_W-1:0]  cache_rd_idx,
    output logic [DC_TAG_W-1:0]  cache_rd_tag,
    input  logic                 cache_rd_valid,
    input  logic [DC_DATA_W-1:0] cache_rd_data,
    // cache fill port
    output logic                 cache_fill_en,
    output logic [DC_IDX_W-1:0]  cache_fill_idx,
    output logic [DC_TAG_W-1:0]  cache_fill_tag,
    output logic [DC_DATA_W-1:0] cache_fill_data,
    // cache store port
    output logic                 cache_st_en,
    output logic [DC_IDX_W-1:0]  cache_st_idx,
    output logic [DC_TAG_W-1:0]  cache_st_tag,
    output logic [DC_DATA_W-1:0] cache_st_data,
    // memory bus
    output logic [1:0]           proc2mem_command,
    output logic [DC_ADDR_W-1:0] proc2mem_addr,
    output logic [DC_DATA_W-1:0] proc2mem_data,
    input  logic [MEM_TAG_W-1:0] mem2proc_response,
    input  logic [DC_DATA_W-1:0] mem2proc_data,
    input  logic [MEM_TAG_W-1:0] mem2proc_tag
);

    dc_state_e            r_state;
    dc_line_addr_t        r_addr;
    logic [DC_DATA_W-1:0] r_st_data;
    logic [MEM_TAG_W-1:0] r_mem_tag;
    logic                 r_resp_valid;
    logic [DC_DATA_W-1:0] r_resp_data;

    logic                 w_idle;
    logic                 w_ld_gnt;
    logic                 w_st_gnt;
    logic                 w_mem_ack;
    logic                 w_tag_hit;
    logic                 w_st_ack;
    logic [5:0]           w_unused_lsb;

    assign w_idle       = (r_state == S_IDLE);
    assign w_unused_lsb = {ld_addr[DC_OFS_W-1:0], st_addr[DC_OFS_W-1:0]};

    dcache_arb u_arb (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_en     (w_idle),
        .i_ld_req (ld_req),
        .i_st_req (st_req),
        .o_ld_gnt (w_ld_gnt),
        .o_st_gnt (w_st_gnt)
    );

    assign w_mem_ack = (mem2proc_response != '0);
    // A zero captured tag never matches, so stale returns after reset are dropped.
    assign w_tag_hit = (r_state == S_LD_WAIT) && (r_mem_tag != '0) && (mem2proc_tag == r_mem_tag);
    assign w_st_ack  = (r_state == S_ST_ISSUE) && w_mem_ack;

    // Controller FSM plus request latch and hit-response register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_st_data    <= '0;
            r_mem_tag    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_ld_gnt) begin
                        r_addr  <= dc_split_addr(ld_addr);
                        r_state <= S_LD_LOOKUP;
                    end else if (w_st_gnt) begin
                        r_addr    <= dc_split_addr(st_addr);
                        r_st_data <= st_data;
                        r_state   <= S_ST_ISSUE;
                    end
                end
                S_LD_LOOKUP: begin
                    if (cache_rd_valid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= cache_rd_data;
                        r_state      <= S_IDLE;
                    end else begin
                        r_state <= S_LD_ISSUE;
                    end
                end
                S_LD_ISSUE: begin
                    if (w_mem_ack) begin
                        r_mem_tag <= mem2proc_response;
                        r_state   <= S_LD_WAIT;
                    end
                end
                S_LD_WAIT: begin
                    if (w_tag_hit) begin
                        r_mem_tag <= '0;
                        r_state   <= S_IDLE;
                    end
                end
                S_ST_ISSUE: begin
                    if (w_st_ack) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bus command follows the issuing states directly.
    always_comb begin
        proc2mem_command = BUS_NONE;
        unique case (r_state)
            S_LD_ISSUE: proc2mem_command = BUS_LOAD;
            S_ST_ISSUE: proc2mem_command = BUS_STORE;
            default:    proc2mem_command = BUS_NONE;
        endcase
    end

    assign ld_ready        = w_ld_gnt;
    assign st_ready        = w_st_gnt;

    assign proc2mem_addr   = {r_addr, {DC_OFS_W{1'b0}}};
    assign proc2mem_data   = r_st_data;

    assign cache_rd_idx    = r_addr.idx;
    assign cache_rd_tag    = r_addr.tag;

    assign cache_fill_en   = w_tag_hit;
    assign cache_fill_idx  = r_addr.idx;
    assign cache_fill_tag  = r_addr.tag;
    assign cache_fill_data = w_tag_hit ? mem2proc_data : '0;

    // Write-allocate: the store port marks the line valid with the new tag.
    assign cache_st_en     = w_st_ack;
    assign cache_st_idx    = r_addr.idx;
    assign cache_st_tag    = r_addr.tag;
    assign cache_st_data   = r_st_data;
    assign st_done         = w_st_ack;

    // Miss data is forwarded in the same cycle it fills the cache.
    assign ld_resp_valid   = r_resp_valid | w_tag_hit;
    assign ld_resp_data    = w_tag_hit ? mem2proc_data : r_resp_data;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized self-checking bench for dcache_ctrl with a line-level cache/memory model.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ld_req;
    logic [15:0] ld_addr;
    logic        ld_ready;
    logic        ld_resp_valid;
    logic [63:0] ld_resp_data;
    logic        st_req;
    logic [15:0] st_addr;
    logic [63:0] st_data;
    logic        st_ready;
    logic        st_done;
    logic [4:0]  cache_rd_idx;
    logic [7:0]  cache_rd_tag;
    logic        cache_rd_valid;
    logic [63:0] cache_rd_data;
    logic        cache_fill_en;
    logic [4:0]  cache_fill_idx;
    logic [7:0]  cache_fill_tag;
    logic [63:0] cache_fill_data;
    logic        cache_st_en;
    logic [4:0]  cache_st_idx;
    logic [7:0]  cache_st_tag;
    logic [63:0] cache_st_data;
    logic [1:0]  proc2mem_command;
    logic [15:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;

    always #5 clock = ~clock;

    dcache_ctrl dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .ld_req            (ld_req),
        .ld_addr           (ld_addr),
        .ld_ready          (ld_ready),
        .ld_resp_valid     (ld_resp_valid),
        .ld_resp_data      (ld_resp_data),
        .st_req            (st_req),
        .st_addr           (st_addr),
        .st_data           (st_data),
        .st_ready          (st_ready),
        .st_done           (st_done),
        .cache_rd_idx      (cache_rd_idx),
        .cache_rd_tag      (cache_rd_tag),
        .cache_rd_valid    (cache_rd_valid),
        .cache_rd_data     (cache_rd_data),
        .cache_fill_en     (cache_fill_en),
        .cache_fill_idx    (cache_fill_idx),
        .cache_fill_tag    (cache_fill_tag),
        .cache_fill_data   (cache_fill_data),
        .cache_st_en       (cache_st_en),
        .cache_st_idx      (cache_st_idx),
        .cache_st_tag      (cache_st_tag),
        .cache_st_data     (cache_st_data),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag)
    );

    // Stand-in for dcache_mem: written by whatever the controller drives.
    logic        env_init = 1'b0;
    logic        env_valid [32];
    logic [7:0]  env_tag   [32];
    logic [63:0] env_data  [32];

    assign cache_rd_valid = env_valid[cache_rd_idx] && (env_tag[cache_rd_idx] == cache_rd_tag);
    assign cache_rd_data  = env_data[cache_rd_idx];

    always @(negedge clock) begin
        if (!env_init) begin
            for (int i = 0; i < 32; i++) begin
                env_valid[i] <= 1'b0;
                env_tag[i]   <= '0;
                env_data[i]  <= '0;
            end
            env_init <= 1'b1;
        end else begin
            if (cache_fill_en) begin
                env_valid[cache_fill_idx] <= 1'b1;
                env_tag[cache_fill_idx]   <= cache_fill_tag;
                env_data[cache_fill_idx]  <= cache_fill_data;
            end
            if (cache_st_en) begin
                env_valid[cache_st_idx] <= 1'b1;
                env_tag[cache_st_idx]   <= cache_st_tag;
                env_data[cache_st_idx]  <= cache_st_data;
            end
        end
    end

    // Reference model: which line holds which tag, plus backing memory.
    // Write-through keeps cached data equal to memory, so hit data comes from mem_model.
    logic        ref_valid [32];
    logic [7:0]  ref_tag   [32];
    logic [63:0] mem_model [logic [15:0]];
    logic        ref_last_st;

    // Per-cycle expectations.
    logic        e_ld_rdy, e_st_rdy, e_resp_v, e_fill, e_st_en;
    logic [1:0]  e_cmd;
    logic [15:0] e_addr;
    logic [63:0] e_data, e_resp_d;
    logic [4:0]  e_idx;
    logic [7:0]  e_tag;
    logic        carry_v;
    logic [63:0] carry_d;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic begin_cycle();
        @(posedge clock);
        #2;
        e_ld_rdy = 1'b0;
        e_st_rdy = 1'b0;
        e_cmd    = 2'd0;
        e_addr   = '0;
        e_data   = '0;
        e_fill   = 1'b0;
        e_st_en  = 1'b0;
        e_idx    = '0;
        e_tag    = '0;
        e_resp_v = carry_v;
        e_resp_d = carry_d;
        carry_v  = 1'b0;
        mem2proc_response = '0;
        mem2proc_tag      = '0;
        mem2proc_data     = {$urandom, $urandom};
    endtask

    task automatic end_cycle();
        #2;
        chk("ld_ready", 64'(ld_ready), 64'(e_ld_rdy));
        chk("st_ready", 64'(st_ready), 64'(e_st_rdy));
        chk("command", 64'(proc2mem_command), 64'(e_cmd));
        if (e_cmd != 2'd0) chk("mem_addr", 64'(proc2mem_addr), 64'(e_addr));
        if (e_cmd == 2'd2) chk("mem_wdata", proc2mem_data, e_data);
        chk("resp_valid", 64'(ld_resp_valid), 64'(e_resp_v));
        if (e_resp_v) chk("resp_data", ld_resp_data, e_resp_d);
        chk("fill_en", 64'(cache_fill_en), 64'(e_fill));
        if (e_fill) begin
            chk("fill_idx", 64'(cache_fill_idx), 64'(e_idx));
            chk("fill_tag", 64'(cache_fill_tag), 64'(e_tag));
            chk("fill_data", cache_fill_data, e_data);
        end
        chk("st_en", 64'(cache_st_en), 64'(e_st_en));
        chk("st_done", 64'(st_done), 64'(e_st_en));
        if (e_st_en) begin
            chk("st_idx", 64'(cache_st_idx), 64'(e_idx));
            chk("st_tag", 64'(cache_st_tag), 64'(e_tag));
            chk("st_data", cache_st_data, e_data);
        end
    endtask

    // One load from acceptance to completion; abort leaves it parked waiting for data.
    task automatic do_load(input logic [15:0] a, input int dly, input logic [3:0] mtag,
                           input int nwrong, input logic hold_st, input logic abort);
        logic [15:0] la;
        logic        hit;
        int          ti;
        la  = {a[15:3], 3'b000};
        hit = ref_valid[a[7:3]] && (ref_tag[a[7:3]] == a[15:8]);
        if (!mem_model.exists(la)) mem_model[la] = {$urandom, $urandom};
        begin_cycle();
        ld_req  = 1'b1;
        ld_addr = a;
        if (hold_st) st_req = 1'b1;
        e_ld_rdy = 1'b1;
        end_cycle();
        ref_last_st = 1'b0;
        begin_cycle();
        ld_req  = 1'b0;
        ld_addr = 16'($urandom);
        end_cycle();
        if (hit) begin
            carry_v = 1'b1;
            carry_d = mem_model[la];
            return;
        end
        for (int i = 0; i <= dly; i++) begin
            begin_cycle();
            e_cmd  = 2'd1;
            e_addr = la;
            if (i == dly) mem2proc_response = mtag;
            end_cycle();
        end
        for (int i = 0; i <= nwrong; i++) begin
            begin_cycle();
            if (i < nwrong) begin
                ti = int'($urandom_range(0, 15));
                if (ti == int'(mtag)) ti = int'(mtag ^ 4'h6);
                mem2proc_tag = 4'(ti);
            end else if (!abort) begin
                mem2proc_tag  = mtag;
                mem2proc_data = mem_model[la];
                e_fill   = 1'b1;
                e_idx    = a[7:3];
                e_tag    = a[15:8];
                e_data   = mem_model[la];
                e_resp_v = 1'b1;
                e_resp_d = mem_model[la];
            end
            end_cycle();
        end
        if (!abort) begin
            ref_valid[a[7:3]] = 1'b1;
            ref_tag[a[7:3]]   = a[15:8];
        end
    endtask

    task automatic do_store(input logic [15:0] a, input logic [63:0] d, input int dly,
                            input logic [3:0] mtag, input logic hold_ld);
        logic [15:0] la;
        la = {a[15:3], 3'b000};
        begin_cycle();
        st_req  = 1'b1;
        st_addr = a;
        st_data = d;
        if (hold_ld) ld_req = 1'b1;
        e_st_rdy = 1'b1;
        end_cycle();
        ref_last_st = 1'b1;
        for (int i = 0; i <= dly; i++) begin
            begin_cycle();
            if (i == 0) begin
                st_req  = 1'b0;
                st_addr = 16'($urandom);
                st_data = {$urandom, $urandom};
            end
            e_cmd  = 2'd2;
            e_addr = la;
            e_data = d;
            if (i == dly) begin
                mem2proc_response = mtag;
                e_st_en = 1'b1;
                e_idx   = a[7:3];
                e_tag   = a[15:8];
            end
            end_cycle();
        end
        mem_model[la]     = d;
        ref_valid[a[7:3]] = 1'b1;
        ref_tag[a[7:3]]   = a[15:8];
    endtask

    // Both requesters raised together; the model picks the winner from the last grant.
    task automatic do_both(input logic [15:0] la, input logic [15:0] sa, input logic [63:0] sd);
        if (ref_last_st) begin
            st_addr = sa;
            st_data = sd;
            do_load(la, int'($urandom_range(0, 3)), 4'($urandom_range(1, 15)),
                    int'($urandom_range(0, 2)), 1'b1, 1'b0);
            do_store(sa, sd, int'($urandom_range(0, 3)), 4'($urandom_range(1, 15)), 1'b0);
        end else begin
            ld_addr = la;
            do_store(sa, sd, int'($urandom_range(0, 3)), 4'($urandom_range(1, 15)), 1'b1);
            do_load(la, int'($urandom_range(0, 3)), 4'($urandom_range(1, 15)),
                    int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        a = {6'd0, 2'($urandom), 5'($urandom_range(0, 7)), 3'($urandom)};
        return a;
    endfunction

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_ready"}, 64'({ld_ready, st_ready}), 64'(0));
        chk({pfx, "_command"}, 64'(proc2mem_command), 64'(0));
        chk({pfx, "_addr"}, 64'(proc2mem_addr), 64'(0));
        chk({pfx, "_resp_valid"}, 64'(ld_resp_valid), 64'(0));
        chk({pfx, "_enables"}, 64'({cache_fill_en, cache_st_en, st_done}), 64'(0));
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        int          op;
        reset_n = 1'b0;
        ld_req  = 1'b0;
        ld_addr = '0;
        st_req  = 1'b0;
        st_addr = '0;
        st_data = '0;
        mem2proc_response = '0;
        mem2proc_tag      = '0;
        mem2proc_data     = '0;
        carry_v = 1'b0;
        carry_d = '0;
        ref_last_st = 1'b1;
        for (int i = 0; i < 32; i++) begin
            ref_valid[i] = 1'b0;
            ref_tag[i]   = '0;
        end
        repeat (2) @(posedge clock);
        #3;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Tie from reset: load goes first, then the store.
        do_both(16'h2210, 16'h3318, 64'h0123_4567_89AB_CDEF);
        // Store allocates idx 7 tag 0x12; load then hits.
        do_store(16'h1238, 64'h1122_3344_5566_7788, 1, 4'd2, 1'b0);
        do_load(16'h1238, 0, 4'd1, 0, 1'b0, 1'b0);
        // Cold miss with delayed acceptance and a foreign tag first.
        mem_model[16'h0450] = 64'hDEAD;
        do_load(16'h0450, 3, 4'd5, 1, 1'b0, 1'b0);
        do_load(16'h0450, 0, 4'd1, 0, 1'b0, 1'b0);
        do_store(16'h0450, 64'hBEEF, 2, 4'd7, 1'b0);
        do_load(16'h0450, 0, 4'd1, 0, 1'b0, 1'b0);
        do_both(16'h0450, 16'h1238, 64'hCAFE_F00D);
        do_both(16'h1238, 16'h2210, 64'h5A5A_A5A5);

        // Reset while waiting for load data; the late tag must be ignored.
        do_load(16'h0F08, 1, 4'd5, 0, 1'b0, 1'b1);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        ref_last_st = 1'b1;
        begin_cycle();
        mem2proc_tag  = 4'd5;
        mem2proc_data = 64'hBAD0_BAD0;
        end_cycle();
        do_load(16'h0F08, 1, 4'd9, 0, 1'b0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(0, 2));
            a  = rand_addr();
            b  = rand_addr();
            if (op == 0) begin
                do_load(a, int'($urandom_range(0, 3)), 4'($urandom_range(1, 15)),
                        int'($urandom_range(0, 2)), 1'b0, 1'b0);
            end else if (op == 1) begin
                do_store(a, {$urandom, $urandom}, int'($urandom_range(0, 3)),
                         4'($urandom_range(1, 15)), 1'b0);
            end else begin
                do_both(a, b, {$urandom, $urandom});
            end
        end
        begin_cycle();
        end_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Blocking controller for the 32-line direct-mapped data cache. Arbitrates one load requester and one store requester onto the cache's lookup/fill/write ports and the single shared memory bus. Handles one transaction at a time: load hit, load miss with fill, or write-through store with write-allocate. Sits between the LSQ-side load/store units and `dcache_mem` plus the memory bus.

## Interface
- DC_IDX_W, 5, cache index width (`DC_SIZE` = 32 lines)
- DC_TAG_W, 8, tag width; address = {tag, idx, 3'b0}, 16 bits
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ld_req / ld_addr  in  1 / 16  load request, 8-byte aligned
- ld_ready  out  1  load accepted this cycle
- ld_resp_valid / ld_resp_data  out  1 / 64  load completion pulse and data
- st_req / st_addr / st_data  in  1 / 16 / 64  full-line store request
- st_ready  out  1  store accepted this cycle
- st_done  out  1  store completion pulse
- cache_rd_idx / cache_rd_tag  out  5 / 8  lookup port to `dcache_mem` load read port
- cache_rd_valid / cache_rd_data  in  1 / 64  lookup result (combinational)
- cache_fill_en / _idx / _tag / _data  out  1/5/8/64  to `dcache_mem` load write port
- cache_st_en / _idx / _tag / _data  out  1/5/8/64  to `dcache_mem` store write port
- proc2mem_command  out  2  NONE=0, LOAD=1, STORE=2
- proc2mem_addr / proc2mem_data  out  16 / 64  memory request
- mem2proc_response  in  4  nonzero = accepted, value = transaction tag
- mem2proc_data / mem2proc_tag  in  64 / 4  returning load data, tag 0 = none

## Operation
- States: IDLE, LD_LOOKUP, LD_ISSUE, LD_WAIT, ST_ISSUE.
- IDLE: ld_ready/st_ready asserted for at most one requester. Only one pending -> grant it. Both pending -> grant side opposite to `last_grant` (reset: last_grant = store, so load wins first tie). Accepted request's address/data latched; last_grant updated.
- Load granted -> LD_LOOKUP: cache_rd_idx/tag from latched address. cache_rd_valid=1 -> ld_resp_valid pulse next cycle with cache_rd_data, -> IDLE. Else -> LD_ISSUE.
- LD_ISSUE: proc2mem_command=LOAD, addr=latched; held until mem2proc_response≠0; tag captured -> LD_WAIT.
- LD_WAIT: command NONE; when mem2proc_tag == captured tag (nonzero): cache_fill_en pulse with mem2proc_data, ld_resp_valid pulse same cycle with same data, captured tag cleared, -> IDLE. Other tags ignored.
- Store granted -> ST_ISSUE: command=STORE, addr/data latched, held until response≠0; that cycle cache_st_en pulse (write-allocate, line marked valid) and st_done pulse, -> IDLE.
- ready outputs 0 in every non-IDLE state; requesters hold req/addr/data until ready.
- cache_rd_* drive latched address when not in LD_LOOKUP (harmless).

## Timing
- Reset (async, reset_n=0): state IDLE, all enables/valids/ready/done 0, command NONE, captured tag 0, data/addr outputs 0. Reset mid-transaction abandons it; late mem2proc_tag ignored since captured tag = 0.
- Load hit: accept cycle T, lookup T+1, ld_resp_valid T+2.
- Load miss: LOAD asserted from T+2 until accepted; response at tag-match cycle; next request accepted one cycle after completion.
- Store: STORE from T+1; st_done in acceptance cycle; earliest re-accept next cycle.
- cache_fill_en and cache_st_en never asserted same cycle (blocking).
- Widths: proc2mem_addr = {tag, idx, 3'b000}; tag/idx extracted as addr[15:8]/addr[7:3]; low 3 bits ignored.

## Structure
- Shared package (`dcache_pkg`): bus command enum (NONE/LOAD/STORE), controller state enum, DC_IDX_W/DC_TAG_W, address-split helper function.
- One sub-module natural: `dcache_arb`, two-requester round-robin arbiter with last_grant register; FSM and datapath latch in `dcache_ctrl`.

## Test plan
- Load 0x1238 after fill of idx 7 tag 0x12 -> ld_resp_valid at T+2, data = filled value, command stays NONE.
- Cold load 0x0450 -> LOAD addr 0x0450 held over 3 cycles response=0, then response=5; mem2proc_tag=5 data 0xDEAD -> fill idx 10 tag 0x04 and ld_resp_data 0xDEAD same cycle; reload hits.
- Store 0x0450 data 0xBEEF -> STORE addr 0x0450, cache_st_en + st_done on accept; following load to 0x0450 hits with 0xBEEF.
- ld_req and st_req held simultaneously from reset -> load served first, then store, then load (alternation); neither ready while busy.
- LD_WAIT with mem2proc_tag=3 when captured 5 -> no fill/response; tag 5 later completes.
- reset_n low during LD_WAIT, release, then mem2proc_tag=5 -> no fill, no response, state IDLE, ld_ready available.
